// File: rtl/csla_pkg.sv
// Shared definitions for the carry-select adder/subtractor family.
// Width defaults, half-split derivation and the full-adder carry primitive.
package csla_pkg;

  localparam int WIDTH_DEFAULT = 64;

  // Split point between the low ripple half and the carry-select high half.
  function automatic int half_of(input int width);
    return width / 2;
  endfunction

  // Majority function: carry out of a single full-adder cell.
  function automatic logic fa_carry(input logic x, input logic y, input logic c);
    return (x & y) | (x & c) | (y & c);
  endfunction

endpackage

// File: rtl/csla_sub_64bit_pipe_if.sv
// Operand/result stream bundle for csla_sub_64bit_pipe.
// Both sides are valid/ready: a beat transfers on any rising edge where valid & ready are both 1.
interface csla_sub_64bit_pipe_if #(
  parameter int WIDTH = 64
);

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             ovf;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output a, b, bin, in_valid, out_ready,
    input  in_ready, diff, bout, ovf, out_valid
  );

  modport slave (
    input  a, b, bin, in_valid, out_ready,
    output in_ready, diff, bout, ovf, out_valid
  );

endinterface

// File: rtl/csla_half_cand.sv
// Combinational HALF-bit ripple pair producing both carry-select candidates.
// o_sum0 assumes carry-in 0, o_sum1 assumes carry-in 1; the top bit of each is the carry out.
module csla_half_cand
  import csla_pkg::*;
#(
  parameter int HALF = 32
) (
  input  logic [HALF-1:0] i_a,
  input  logic [HALF-1:0] i_b,
  output logic [HALF:0]   o_sum0,
  output logic [HALF:0]   o_sum1
);

  always_comb begin : p_ripple_pair
    logic w_c0;
    logic w_c1;
    w_c0   = 1'b0;
    w_c1   = 1'b1;
    o_sum0 = '0;
    o_sum1 = '0;
    for (int i = 0; i < HALF; i++) begin
      o_sum0[i] = i_a[i] ^ i_b[i] ^ w_c0;
      o_sum1[i] = i_a[i] ^ i_b[i] ^ w_c1;
      w_c0      = fa_carry(i_a[i], i_b[i], w_c0);
      w_c1      = fa_carry(i_a[i], i_b[i], w_c1);
    end
    o_sum0[HALF] = w_c0;
    o_sum1[HALF] = w_c1;
  end

endmodule

// File: rtl/csla_sub_64bit_pipe.sv
// Two-stage pipelined carry-select subtractor: diff = a - b - bin, computed as a + ~b + ~bin.
// Stage 1 holds the low-half sum and both high-half candidates; stage 2 selects and registers results.
module csla_sub_64bit_pipe
  import csla_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  csla_sub_64bit_pipe_if.slave  bus
);

  localparam int HALF = half_of(WIDTH);

  logic [WIDTH-1:0] w_b_inv;
  logic [HALF:0]    w_lo_sum;
  logic [HALF:0]    w_hi_sum0;
  logic [HALF:0]    w_hi_sum1;
  logic             w_adv1;
  logic             w_adv2;
  logic             w_accept;

  logic             r_s1_valid;
  logic [HALF-1:0]  r_s_lo;
  logic             r_c_lo;
  logic [HALF:0]    r_hi0;
  logic [HALF:0]    r_hi1;
  logic             r_a_msb;
  logic             r_b_msb;

  logic             r_out_valid;
  logic [WIDTH-1:0] r_diff;
  logic             r_bout;
  logic             r_ovf;

  logic [HALF:0]    w_hi_sel;
  logic [WIDTH-1:0] w_diff_nxt;
  logic             w_bout_nxt;
  logic             w_ovf_nxt;

  // Ready depends only on the valid bits and out_ready, never on in_valid.
  assign w_adv2       = !r_out_valid | bus.out_ready;
  assign w_adv1       = !r_s1_valid | w_adv2;
  assign w_accept     = bus.in_valid & w_adv1;
  assign bus.in_ready = w_adv1;

  assign w_b_inv = ~bus.b;

  // Low half: single ripple chain whose carry-in is the inverted borrow-in.
  always_comb begin : p_lo_ripple
    logic w_c;
    w_c      = ~bus.bin;
    w_lo_sum = '0;
    for (int i = 0; i < HALF; i++) begin
      w_lo_sum[i] = bus.a[i] ^ w_b_inv[i] ^ w_c;
      w_c         = fa_carry(bus.a[i], w_b_inv[i], w_c);
    end
    w_lo_sum[HALF] = w_c;
  end

  csla_half_cand #(
    .HALF (HALF)
  ) u_hi_cand (
    .i_a    (bus.a[WIDTH-1:HALF]),
    .i_b    (w_b_inv[WIDTH-1:HALF]),
    .o_sum0 (w_hi_sum0),
    .o_sum1 (w_hi_sum1)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s_lo     <= '0;
      r_c_lo     <= 1'b0;
      r_hi0      <= '0;
      r_hi1      <= '0;
      r_a_msb    <= 1'b0;
      r_b_msb    <= 1'b0;
    end else begin
      if (w_adv1) begin
        r_s1_valid <= bus.in_valid;
      end
      if (w_accept) begin
        r_s_lo  <= w_lo_sum[HALF-1:0];
        r_c_lo  <= w_lo_sum[HALF];
        r_hi0   <= w_hi_sum0;
        r_hi1   <= w_hi_sum1;
        r_a_msb <= bus.a[WIDTH-1];
        r_b_msb <= bus.b[WIDTH-1];
      end
    end
  end

  // The low-half carry is the only path by which a borrow crosses the split.
  assign w_hi_sel   = r_c_lo ? r_hi1 : r_hi0;
  assign w_diff_nxt = {w_hi_sel[HALF-1:0], r_s_lo};
  assign w_bout_nxt = ~w_hi_sel[HALF];
  assign w_ovf_nxt  = (r_a_msb != r_b_msb) & (w_hi_sel[HALF-1] != r_a_msb);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_diff      <= '0;
      r_bout      <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      if (w_adv2) begin
        r_out_valid <= r_s1_valid;
      end
      if (w_adv2 && r_s1_valid) begin
        r_diff <= w_diff_nxt;
        r_bout <= w_bout_nxt;
        r_ovf  <= w_ovf_nxt;
      end
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.diff      = r_diff;
  assign bus.bout      = r_bout;
  assign bus.ovf       = r_ovf;

endmodule
